// File: rtl/bcd_serial_subtractor.sv
// bcd_serial_subtractor: digit-serial packed-BCD x - y, LSD first, registered borrow, start/busy/done handshake.
// Define BCD_SUB_SIGN_MAG_EN to return |x-y| with bout as the sign instead of the ten's complement.
module bcd_serial_subtractor #(
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [4*DIGITS-1:0] x,
    input  logic [4*DIGITS-1:0] y,
    output logic [4*DIGITS-1:0] out,
    output logic                bout,
    output logic                err,
    output logic                busy,
    output logic                done
);
    localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
    localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

`ifdef BCD_SUB_SIGN_MAG_EN
    typedef enum logic [1:0] {IDLE, RUN, DONE, COMP} state_t;
`else
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
`endif

    state_t state, state_nx;
    logic [4*DIGITS-1:0] xr, yr;
    logic [IW-1:0] idx;
    logic borrow, accept, last, in_err;
    logic [3:0] a, b, d;
    logic [4:0] t;

`ifdef BCD_SUB_SIGN_MAG_EN
    // COMP negates the stored result in place: 0 - out_i with a fresh borrow chain
    assign a = state == COMP ? 4'd0 : xr[4*idx +: 4];
    assign b = state == COMP ? out[4*idx +: 4] : yr[4*idx +: 4];
    assign busy = state == RUN || state == COMP;
`else
    assign a = xr[4*idx +: 4];
    assign b = yr[4*idx +: 4];
    assign busy = state == RUN;
`endif

    assign done = state == DONE;
    assign accept = start && !busy;
    assign last = idx == LAST;
    assign t = {1'b0, a} - {1'b0, b} - {4'd0, borrow};
    assign d = t[4] ? t[3:0] + 4'd10 : t[3:0];

    always_comb begin
        in_err = 1'b0;
        for (int i = 0; i < DIGITS; i++)
            in_err = in_err | (x[4*i +: 4] > 4'd9) | (y[4*i +: 4] > 4'd9);
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: state_nx = start ? RUN : IDLE;
`ifdef BCD_SUB_SIGN_MAG_EN
            RUN:  state_nx = last ? (t[4] ? COMP : DONE) : RUN;
            COMP: state_nx = last ? DONE : COMP;
`else
            RUN:  state_nx = last ? DONE : RUN;
`endif
            DONE: state_nx = start ? RUN : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xr     <= '0;
            yr     <= '0;
            out    <= '0;
            bout   <= 1'b0;
            err    <= 1'b0;
            idx    <= '0;
            borrow <= 1'b0;
        end else if (accept) begin
            xr     <= x;
            yr     <= y;
            out    <= '0;
            bout   <= 1'b0;
            err    <= in_err;
            idx    <= '0;
            borrow <= 1'b0;
        end else if (busy) begin
            out[4*idx +: 4] <= d;
            idx    <= last ? '0 : idx + 1'b1;
            borrow <= last ? 1'b0 : t[4];
            if (state == RUN && last)
                bout <= t[4];
        end
    end
endmodule

// File: tb/tb_bcd_serial_subtractor.sv
// tb_bcd_serial_subtractor: random and directed stimulus checked every cycle against an integer-arithmetic model.
`timescale 1ns/1ps
module tb_bcd_serial_subtractor;
    localparam int D = 4;
    localparam int W = 4*D;

    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic [W-1:0] x = '0, y = '0, out;
    logic bout, err, busy, done;
    int checks = 0, errors = 0;

    bcd_serial_subtractor #(.DIGITS(D)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .x(x), .y(y),
        .out(out), .bout(bout), .err(err), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", name, got, want, $time);
        end
    endtask

    function automatic int bcd_val(input logic [W-1:0] v);
        int s = 0;
        for (int i = D-1; i >= 0; i--) s = s*10 + int'(v[4*i +: 4]);
        return s;
    endfunction

    function automatic logic [W-1:0] to_bcd(input int v);
        logic [W-1:0] r = '0;
        for (int i = 0; i < D; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic logic [W-1:0] rnd_bcd();
        logic [W-1:0] r = '0;
        for (int i = 0; i < D; i++) r[4*i +: 4] = 4'($urandom_range(0, 9));
        return r;
    endfunction

    // Model: an accepted op at edge s_edge keeps busy through edge s_edge+lat-1, done after s_edge+lat
    int n = 0, s_edge = 0, lat = 0;
    bit active = 0, out_known = 1;
    logic [W-1:0] m_out = '0;
    logic m_bout = 1'b0, m_err = 1'b0;

    always @(posedge clk or negedge rst_n) begin : model
        int diff;
        bit ok;
        if (!rst_n) begin
            active = 0; out_known = 1; m_out = '0; m_bout = 1'b0; m_err = 1'b0;
        end else begin
            n++;
            if (start && !(active && n-1 >= s_edge && n-1 < s_edge + lat)) begin
                ok = 1;
                for (int i = 0; i < D; i++)
                    if (x[4*i +: 4] > 4'd9 || y[4*i +: 4] > 4'd9) ok = 0;
                diff = bcd_val(x) - bcd_val(y);
                m_bout = diff < 0;
                m_err = !ok;
`ifdef BCD_SUB_SIGN_MAG_EN
                m_out = to_bcd(diff < 0 ? -diff : diff);
                lat = diff < 0 ? 2*D : D;
`else
                m_out = to_bcd(diff < 0 ? diff + 10**D : diff);
                lat = D;
`endif
                out_known = ok; s_edge = n; active = 1;
            end
        end
    end

    always @(negedge clk) begin : cmp
        bit b_exp, d_exp, settled;
        b_exp = active && n >= s_edge && n < s_edge + lat;
        d_exp = active && n == s_edge + lat;
        settled = !active || n >= s_edge + lat;
        check("busy", busy, b_exp);
        check("done", done, d_exp);
        if (settled) begin
            check("err", err, m_err);
            check("bout", bout, m_bout);
            if (out_known) check("out", out, m_out);
        end
    end

    task automatic wait_done(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!done && cyc < 40);
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL done_timeout got no done want done within 40 cycles");
        end
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("idle_timeout", busy, 0);
    endtask

    task automatic op(input logic [W-1:0] xa, input logic [W-1:0] ya, output int cyc);
        int c;
        @(negedge clk);
        x = xa; y = ya; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        c = 1;
        while (!done && c < 40) begin
            @(negedge clk);
            c++;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL op_timeout got no done want done within 40 cycles");
        end
        cyc = c;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got no finish want finish");
        $fatal(1);
    end

    initial begin
        int c;
        repeat (3) @(negedge clk);
        check("rst_out", out, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_bout", bout, 0);
        check("rst_err", err, 0);
        rst_n = 1'b1;

        op(16'h5432, 16'h1234, c);
        check("lat_basic", c, D + 1);
        check("out_basic", out, 16'h4198);
        check("bout_basic", bout, 0);
        check("err_basic", err, 0);

        op(16'h1000, 16'h0001, c);
        check("out_ripple", out, 16'h0999);
        check("bout_ripple", bout, 0);

        op(16'h0012, 16'h0034, c);
        check("bout_neg", bout, 1);
`ifdef BCD_SUB_SIGN_MAG_EN
        check("out_neg", out, 16'h0022);
        check("lat_neg", c, 2*D + 1);
`else
        check("out_neg", out, 16'h9978);
        check("lat_neg", c, D + 1);
`endif

        op(16'h00A5, 16'h0001, c);
        check("err_inv", err, 1);
        check("bout_inv", bout, 0);

        @(negedge clk);
        x = 16'h0009; y = 16'h0009; start = 1'b1;
        wait_done(c);
        check("out_held", out, 16'h0000);
        check("lat_held", c, D + 1);
        @(negedge clk);
        check("b2b_busy", busy, 1);
        check("b2b_done", done, 0);
        start = 1'b0;
        wait_idle();

        @(negedge clk);
        x = 16'h5A32; y = 16'h1234; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        check("pre_rst_err", err, 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_out", out, 0);
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_err", err, 0);
        check("arst_bout", bout, 0);
        @(negedge clk);
        rst_n = 1'b1;
        op(16'h9999, 16'h0000, c);
        check("out_post_rst", out, 16'h9999);
        check("lat_post_rst", c, D + 1);

        for (int k = 0; k < 800; k++) begin
            @(negedge clk);
            x = rnd_bcd();
            y = ($urandom_range(0, 7) == 0) ? x : rnd_bcd();
            start = $urandom_range(0, 2) == 0;
        end
        @(negedge clk);
        start = 1'b0;
        wait_idle();
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
